gyruss_spram_server: RTL and testbench

Sprite attribute RAM responder for the Gyruss sprite path. The block owns the 256-byte sprite attribute table. It accepts CPU reads and writes into a work bank. On every vertical blank it copies the work bank into the idle one of two display banks, then swaps display banks. It answers the sprite engine's byte-address fetches (SPAA → SPAD) from the active display bank, so the engine always scans a coherent, frame-stable table while the CPU edits the next frame.

---
 rtl/gyruss_spram_server_pkg.sv | 25 ++
 rtl/gyruss_spram_bank.sv | 34 +++
 rtl/gyruss_spram_server.sv | 171 +++++++++++++++++
 tb/tb_gyruss_spram_server.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gyruss_spram_server_pkg.sv
// Shared types and constants for the Gyruss sprite attribute RAM server.
// Holds the FSM state encodings and the layout of one sprite's attribute bytes.
package gyruss_spram_server_pkg;

    localparam int SPR_AW = 8;
    localparam int SPR_DW = 8;

    // Byte offsets inside one 4-byte sprite attribute record
    localparam logic [1:0] OFS_X    = 2'd0;
    localparam logic [1:0] OFS_CODE = 2'd1;
    localparam logic [1:0] OFS_ATTR = 2'd2;
    localparam logic [1:0] OFS_Y    = 2'd3;

    typedef enum logic [1:0] {
        CP_IDLE,
        CP_COPY,
        CP_SWAP
    } copy_state_t;

    typedef enum logic {
        C_IDLE,
        C_ACK
    } cpu_state_t;

endpackage

// File: rtl/gyruss_spram_bank.sv
// Generic single-clock RAM: one write port, one registered read port.
// Array contents are never reset; only the read register is.
module gyruss_spram_bank
    import gyruss_spram_server_pkg::*;
#(
    parameter int AW = SPR_AW,
    parameter int DW = SPR_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [(1<<AW)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/gyruss_spram_server.sv
// Sprite attribute RAM: CPU edits a work bank, VBLK copies it into the idle
// display bank and swaps, the sprite engine reads the active display bank.
//
// copy FSM  state   | meaning
//           CP_IDLE | waiting for VBLK rise, CPU may use the work bank
//           CP_COPY | streaming work bank into display bank ~BANK
//           CP_SWAP | flip BANK, drop BUSY
// cpu FSM   C_IDLE  | waiting for a granted CPUREQ
//           C_ACK   | access done, pulse CPUACK
module gyruss_spram_server
    import gyruss_spram_server_pkg::*;
#(
    parameter int AW = SPR_AW,
    parameter int DW = SPR_DW
) (
    input  logic          VCLKx8,
    input  logic          RESET_N,
    input  logic          VBLK,
    input  logic          CPUREQ,
    input  logic          CPUWR,
    input  logic [AW-1:0] CPUAD,
    input  logic [DW-1:0] CPUDI,
    output logic [DW-1:0] CPUDO,
    output logic          CPUACK,
    input  logic [AW-1:0] SPAA,
    output logic [DW-1:0] SPAD,
    output logic          BANK,
    output logic          BUSY,
    output logic          OVR
);

    copy_state_t   cp_state;
    cpu_state_t    cpu_state;
    logic          vblk_q;
    logic [AW-1:0] cnt;
    logic          sel_q;
    logic          cpu_rd;

    logic          vblk_rise;
    logic          cpu_go;
    logic          copy_we;
    logic [AW-1:0] w_raddr;
    logic [DW-1:0] w_rdata;
    logic [DW-1:0] d0_rdata;
    logic [DW-1:0] d1_rdata;

    assign vblk_rise = VBLK & ~vblk_q;
    // The copy owns the work bank, including the very cycle its VBLK edge is seen
    assign cpu_go    = (cpu_state == C_IDLE) && CPUREQ && (cp_state == CP_IDLE) && !vblk_rise;
    assign copy_we   = (cp_state == CP_COPY);

    // Work-bank read runs one address ahead of the display-bank write
    always_comb begin
        w_raddr = CPUAD;
        if (cp_state == CP_COPY) begin
            w_raddr = cnt + AW'(1);
        end else if (vblk_rise) begin
            w_raddr = '0;
        end
    end

    gyruss_spram_bank #(.AW(AW), .DW(DW)) u_work (
        .clk   (VCLKx8),
        .rst_n (RESET_N),
        .we    (cpu_go & CPUWR),
        .waddr (CPUAD),
        .wdata (CPUDI),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    gyruss_spram_bank #(.AW(AW), .DW(DW)) u_disp0 (
        .clk   (VCLKx8),
        .rst_n (RESET_N),
        .we    (copy_we & BANK),
        .waddr (cnt),
        .wdata (w_rdata),
        .raddr (SPAA),
        .rdata (d0_rdata)
    );

    gyruss_spram_bank #(.AW(AW), .DW(DW)) u_disp1 (
        .clk   (VCLKx8),
        .rst_n (RESET_N),
        .we    (copy_we & ~BANK),
        .waddr (cnt),
        .wdata (w_rdata),
        .raddr (SPAA),
        .rdata (d1_rdata)
    );

    // sel_q is BANK as it was when SPAA was sampled, so SPAD never mixes frames
    assign SPAD = sel_q ? d1_rdata : d0_rdata;

    always_ff @(posedge VCLKx8 or negedge RESET_N) begin
        if (!RESET_N) begin
            cp_state <= CP_IDLE;
            cnt      <= '0;
            vblk_q   <= 1'b0;
            sel_q    <= 1'b0;
            BANK     <= 1'b0;
            BUSY     <= 1'b0;
            OVR      <= 1'b0;
        end else begin
            vblk_q <= VBLK;
            sel_q  <= BANK;
            case (cp_state)
                CP_IDLE: begin
                    if (vblk_rise) begin
                        cp_state <= CP_COPY;
                        cnt      <= '0;
                        BUSY     <= 1'b1;
                    end
                end
                CP_COPY: begin
                    if (vblk_rise) begin
                        OVR <= 1'b1;
                    end
                    if (cnt == '1) begin
                        cp_state <= CP_SWAP;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                CP_SWAP: begin
                    if (vblk_rise) begin
                        OVR <= 1'b1;
                    end
                    BANK     <= ~BANK;
                    BUSY     <= 1'b0;
                    cp_state <= CP_IDLE;
                end
                default: begin
                    cp_state <= CP_IDLE;
                    BUSY     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge VCLKx8 or negedge RESET_N) begin
        if (!RESET_N) begin
            cpu_state <= C_IDLE;
            cpu_rd    <= 1'b0;
            CPUACK    <= 1'b0;
            CPUDO     <= '0;
        end else begin
            case (cpu_state)
                C_IDLE: begin
                    CPUACK <= 1'b0;
                    if (cpu_go) begin
                        cpu_state <= C_ACK;
                        cpu_rd    <= ~CPUWR;
                    end
                end
                C_ACK: begin
                    CPUACK <= 1'b1;
                    if (cpu_rd) begin
                        CPUDO <= w_rdata;
                    end
                    cpu_state <= C_IDLE;
                end
                default: begin
                    cpu_state <= C_IDLE;
                    CPUACK    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gyruss_spram_server.sv
// Directed bench for gyruss_spram_server: CPU access, copy/swap timing,
// frame-stable sprite reads, overrun flag and reset during a copy.
module tb_gyruss_spram_server;
    import gyruss_spram_server_pkg::*;

    localparam int AW = SPR_AW;
    localparam int DW = SPR_DW;

    logic          VCLKx8  = 1'b0;
    logic          RESET_N = 1'b0;
    logic          VBLK    = 1'b0;
    logic          CPUREQ  = 1'b0;
    logic          CPUWR   = 1'b0;
    logic [AW-1:0] CPUAD   = '0;
    logic [DW-1:0] CPUDI   = '0;
    logic [AW-1:0] SPAA    = '0;
    logic [DW-1:0] CPUDO;
    logic          CPUACK;
    logic [DW-1:0] SPAD;
    logic          BANK;
    logic          BUSY;
    logic          OVR;

    int checks = 0;
    int errors = 0;

    gyruss_spram_server #(.AW(AW), .DW(DW)) dut (
        .VCLKx8  (VCLKx8),
        .RESET_N (RESET_N),
        .VBLK    (VBLK),
        .CPUREQ  (CPUREQ),
        .CPUWR   (CPUWR),
        .CPUAD   (CPUAD),
        .CPUDI   (CPUDI),
        .CPUDO   (CPUDO),
        .CPUACK  (CPUACK),
        .SPAA    (SPAA),
        .SPAD    (SPAD),
        .BANK    (BANK),
        .BUSY    (BUSY),
        .OVR     (OVR)
    );

    always #5 VCLKx8 = ~VCLKx8;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns negedges until CPUACK is seen and the read data.
    task automatic cpu_access(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              output int lat, output logic [DW-1:0] rd);
        CPUREQ = 1'b1;
        CPUWR  = wr;
        CPUAD  = addr;
        CPUDI  = data;
        lat    = 0;
        do begin
            @(negedge VCLKx8);
            lat++;
        end while (!CPUACK && lat < 600);
        rd     = CPUDO;
        CPUREQ = 1'b0;
        if (!CPUACK) check("cpu_ack_timeout", CPUACK, 1);
    endtask

    // One-cycle VBLK pulse, then count cycles BUSY stays high.
    task automatic vblk_copy(output int busy_n);
        VBLK = 1'b1;
        @(negedge VCLKx8);
        VBLK   = 1'b0;
        busy_n = 0;
        while (BUSY && busy_n < 400) begin
            busy_n++;
            @(negedge VCLKx8);
        end
    endtask

    task automatic spad_read(input logic [AW-1:0] addr, output logic [DW-1:0] data);
        SPAA = addr;
        @(negedge VCLKx8);
        data = SPAD;
    endtask

    int            lat;
    int            busy_n;
    int            lat_busy;
    int            toggles;
    logic          prev_bank;
    logic [DW-1:0] rd;
    logic [DW-1:0] exp_b;

    initial begin
        repeat (3) @(negedge VCLKx8);
        check("rst_spad",   SPAD,   0);
        check("rst_cpudo",  CPUDO,  0);
        check("rst_cpuack", CPUACK, 0);
        check("rst_bank",   BANK,   0);
        check("rst_busy",   BUSY,   0);
        check("rst_ovr",    OVR,    0);
        RESET_N = 1'b1;
        repeat (2) @(negedge VCLKx8);

        // Single write and read-back with two-edge round trip
        cpu_access(1'b1, 8'h3C, 8'hA5, lat, rd);
        check("wr_latency", lat, 2);
        cpu_access(1'b0, 8'h3C, 8'h00, lat, rd);
        check("rd_latency", lat, 2);
        check("rd_data", rd, 8'hA5);

        // Fill, copy into D1, sweep
        for (int a = 0; a < 256; a++) begin
            cpu_access(1'b1, 8'(a), 8'(a) ^ 8'h5A, lat, rd);
        end
        vblk_copy(busy_n);
        check("copy1_busy_cycles", busy_n, 257);
        check("copy1_bank", BANK, 1);
        for (int a = 0; a < 256; a++) begin
            spad_read(8'(a), rd);
            check("sweep1_spad", rd, 8'(a) ^ 8'h5A);
        end

        // Copy 2: held SPAA across swap, CPU write stalled by copy
        cpu_access(1'b1, 8'h10, 8'h77, lat, rd);
        SPAA = 8'h10;
        repeat (2) @(negedge VCLKx8);
        prev_bank = BANK;
        lat_busy  = 0;
        fork
            vblk_copy(busy_n);
            begin
                repeat (6) @(negedge VCLKx8);
                cpu_access(1'b1, 8'h20, 8'hC3, lat_busy, rd);
            end
            begin
                for (int i = 0; i < 270; i++) begin
                    @(negedge VCLKx8);
                    exp_b = prev_bank ? 8'h4A : 8'h77;
                    check("spad_frame_hold", SPAD, exp_b);
                    prev_bank = BANK;
                end
            end
        join
        check("copy2_busy_cycles", busy_n, 257);
        check("copy2_bank", BANK, 0);
        check("stalled_cpu_latency", lat_busy, 254);
        spad_read(8'h20, rd);
        check("late_write_not_in_frame", rd, 8'h7A);
        spad_read(8'h10, rd);
        check("copy2_spad_10", rd, 8'h77);
        check("ovr_still_clear", OVR, 0);

        // Copy 3 with a second VBLK edge 100 cycles in
        toggles = 0;
        fork
            vblk_copy(busy_n);
            begin
                repeat (100) @(negedge VCLKx8);
                VBLK = 1'b1;
                @(negedge VCLKx8);
                VBLK = 1'b0;
            end
            begin
                logic pb;
                pb = BANK;
                repeat (300) begin
                    @(negedge VCLKx8);
                    if (BANK != pb) toggles++;
                    pb = BANK;
                end
            end
        join
        check("copy3_busy_cycles", busy_n, 257);
        check("overrun_flag", OVR, 1);
        check("overrun_toggles", toggles, 1);
        check("copy3_bank", BANK, 1);
        spad_read(8'h20, rd);
        check("late_write_next_frame", rd, 8'hC3);

        // Reset at copy count 128, then a full copy into D1
        cpu_access(1'b1, 8'h00, 8'h11, lat, rd);
        cpu_access(1'b1, 8'h80, 8'h99, lat, rd);
        cpu_access(1'b1, 8'hFF, 8'hEE, lat, rd);
        VBLK = 1'b1;
        @(negedge VCLKx8);
        VBLK = 1'b0;
        repeat (128) @(negedge VCLKx8);
        check("pre_reset_busy", BUSY, 1);
        RESET_N = 1'b0;
        @(negedge VCLKx8);
        check("mid_rst_spad",   SPAD,   0);
        check("mid_rst_cpudo",  CPUDO,  0);
        check("mid_rst_cpuack", CPUACK, 0);
        check("mid_rst_bank",   BANK,   0);
        check("mid_rst_busy",   BUSY,   0);
        check("mid_rst_ovr",    OVR,    0);
        RESET_N = 1'b1;
        repeat (3) @(negedge VCLKx8);
        check("post_rst_busy_idle", BUSY, 0);
        vblk_copy(busy_n);
        check("copy4_busy_cycles", busy_n, 257);
        check("copy4_bank", BANK, 1);
        spad_read(8'h00, rd);
        check("copy4_spad_00", rd, 8'h11);
        spad_read(8'h80, rd);
        check("copy4_spad_80", rd, 8'h99);
        spad_read(8'hFF, rd);
        check("copy4_spad_ff", rd, 8'hEE);
        spad_read(8'h10, rd);
        check("copy4_spad_10", rd, 8'h77);
        spad_read(8'h20, rd);
        check("copy4_spad_20", rd, 8'hC3);
        spad_read(8'h3C, rd);
        check("copy4_spad_3c", rd, 8'h66);
        spad_read({6'd5, OFS_Y}, rd);
        check("copy4_spad_sprite5_y", rd, 8'h17 ^ 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
